// File: rtl/wave_capture_tx_if.sv
// wave_capture_tx_if: byte stream from the capture engine to a UART transmitter.
//   tx_data  : byte to send
//   tx_valid : tx_data valid, held until accepted
//   tx_ready : transmitter can accept; transfer when tx_valid && tx_ready
interface wave_capture_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/wave_capture_tx.sv
// wave_capture_tx: captures ADC (and optionally FIR) samples into on-chip RAM while an
// acquire switch is held, then streams a framed dump over a byte handshake.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   adc_data/fir_data : sample inputs, qualified by adc_valid
//   acquireWave/FIR   : capture request levels (rising edge starts a capture)
//   tx                : byte stream master (tx_data/tx_valid/tx_ready)
//   wavenum           : count of completed frames
//   busy              : high whenever not idle
module wave_capture_tx #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned ADC_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADC_W-1:0]         adc_data,
    input  logic [15:0]              fir_data,
    input  logic                     adc_valid,
    input  logic                     acquireWave,
    input  logic                     acquireFIR,
    wave_capture_tx_if.master        tx,
    output logic [15:0]              wavenum,
    output logic                     busy
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [15:0] DepthN = 16'(DEPTH);

    typedef enum logic [2:0] {
        StIdle, StCapture, StSendHdr, StSendWave, StSendFir, StDone
    } state_e;

    // Per-sample readout: address settles, RAM data arrives, high byte, low byte.
    typedef enum logic [1:0] {PhAddr, PhData, PhHi, PhLo} phase_e;

    state_e      state_q;
    phase_e      phase_q;
    logic        wave_prev_q, fir_prev_q;
    logic        armed_q;
    logic        mode_fir_q;
    logic [15:0] n_q;
    logic [15:0] idx_q;
    logic [2:0]  hdr_cnt_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic [15:0] wavenum_q;
    logic        busy_q;

    logic [ADC_W-1:0] wave_mem [DEPTH];
    logic [15:0]      fir_mem  [DEPTH];
    logic [ADC_W-1:0] wave_rd_q;
    logic [15:0]      fir_rd_q;

    logic        wave_rise, fir_rise, mode_acq, wr_en, tx_free;
    logic [15:0] sample;
    logic [7:0]  hdr_byte;

    // armed_q masks the first cycle after reset so a level held through reset is no edge.
    assign wave_rise = armed_q && acquireWave && !wave_prev_q;
    assign fir_rise  = armed_q && acquireFIR && !fir_prev_q;
    assign mode_acq  = mode_fir_q ? acquireFIR : acquireWave;
    assign wr_en     = (state_q == StCapture) && mode_acq && adc_valid;
    assign tx_free   = !tx_valid_q || tx.tx_ready;
    assign sample    = (state_q == StSendFir) ? fir_rd_q : 16'(wave_rd_q);

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_cnt_q)
            3'd0:    hdr_byte = 8'hAA;
            3'd1:    hdr_byte = mode_fir_q ? 8'h69 : 8'h77;
            3'd2:    hdr_byte = n_q[15:8];
            3'd3:    hdr_byte = n_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Sample RAMs: not reset; read address is idx_q, one-cycle latency.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            wave_mem[n_q[AW-1:0]] <= adc_data;
            if (mode_fir_q) begin
                fir_mem[n_q[AW-1:0]] <= fir_data;
            end
        end
        wave_rd_q <= wave_mem[idx_q[AW-1:0]];
        fir_rd_q  <= fir_mem[idx_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            phase_q     <= PhAddr;
            wave_prev_q <= 1'b0;
            fir_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            mode_fir_q  <= 1'b0;
            n_q         <= 16'd0;
            idx_q       <= 16'd0;
            hdr_cnt_q   <= 3'd0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            wavenum_q   <= 16'd0;
            busy_q      <= 1'b0;
        end else begin
            wave_prev_q <= acquireWave;
            fir_prev_q  <= acquireFIR;
            armed_q     <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (wave_rise || fir_rise) begin
                        state_q    <= StCapture;
                        mode_fir_q <= acquireFIR;
                        n_q        <= 16'd0;
                        busy_q     <= 1'b1;
                    end
                end
                StCapture: begin
                    if (!mode_acq) begin
                        state_q   <= StSendHdr;
                        hdr_cnt_q <= 3'd0;
                    end else if (adc_valid) begin
                        n_q <= n_q + 16'd1;
                        if (n_q + 16'd1 == DepthN) begin
                            state_q   <= StSendHdr;
                            hdr_cnt_q <= 3'd0;
                        end
                    end
                end
                StSendHdr: begin
                    if (tx_free) begin
                        if (hdr_cnt_q == 3'd4) begin
                            tx_valid_q <= 1'b0;
                            idx_q      <= 16'd0;
                            phase_q    <= PhAddr;
                            state_q    <= (n_q == 16'd0) ? StDone : StSendWave;
                        end else begin
                            tx_data_q  <= hdr_byte;
                            tx_valid_q <= 1'b1;
                            hdr_cnt_q  <= hdr_cnt_q + 3'd1;
                        end
                    end
                end
                StSendWave, StSendFir: begin
                    unique case (phase_q)
                        PhAddr: phase_q <= PhData;
                        PhData: begin
                            tx_data_q  <= sample[15:8];
                            tx_valid_q <= 1'b1;
                            phase_q    <= PhHi;
                        end
                        PhHi: begin
                            if (tx.tx_ready) begin
                                tx_data_q <= sample[7:0];
                                phase_q   <= PhLo;
                            end
                        end
                        PhLo: begin
                            if (tx.tx_ready) begin
                                tx_valid_q <= 1'b0;
                                phase_q    <= PhAddr;
                                if (idx_q + 16'd1 == n_q) begin
                                    idx_q   <= 16'd0;
                                    state_q <= (state_q == StSendWave && mode_fir_q) ?
                                               StSendFir : StDone;
                                end else begin
                                    idx_q <= idx_q + 16'd1;
                                end
                            end
                        end
                        default: phase_q <= PhAddr;
                    endcase
                end
                StDone: begin
                    wavenum_q <= wavenum_q + 16'd1;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign wavenum     = wavenum_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_wave_capture_tx.sv
module tb_wave_capture_tx;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned ADC_W = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [ADC_W-1:0] adc_data = '0;
    logic [15:0]      fir_data = '0;
    logic             adc_valid = 1'b0;
    logic             acquireWave = 1'b0;
    logic             acquireFIR = 1'b0;
    logic [15:0]      wavenum;
    logic             busy;

    wave_capture_tx_if tx_if ();

    wave_capture_tx #(.DEPTH(DEPTH), .ADC_W(ADC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .adc_data   (adc_data),
        .fir_data   (fir_data),
        .adc_valid  (adc_valid),
        .acquireWave(acquireWave),
        .acquireFIR (acquireFIR),
        .tx         (tx_if),
        .wavenum    (wavenum),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         wn_chg_cyc = 0;
    logic [15:0] wn_prev = 16'h0;
    bit         stalled_prev = 1'b0;
    logic [7:0] stall_data = 8'h0;
    int         stall_viol = 0;
    int         stall_seen = 0;
    bit         bp_en = 1'b0;

    logic [7:0] exp_wave [14] = '{8'hAA, 8'h77, 8'h00, 8'h05, 8'h00, 8'h01, 8'h00, 8'h02,
                                  8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05};
    logic [7:0] exp_fir  [16] = '{8'hAA, 8'h69, 8'h00, 8'h03, 8'h0A, 8'hBC, 8'h0A, 8'hBC,
                                  8'h0A, 8'hBC, 8'h12, 8'h34, 8'h12, 8'h34, 8'h12, 8'h34};
    logic [7:0] exp_both [8]  = '{8'hAA, 8'h69, 8'h00, 8'h01, 8'h00, 8'h0F, 8'h00, 8'h42};
    logic [7:0] exp_zero [4]  = '{8'hAA, 8'h77, 8'h00, 8'h00};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        tx_if.tx_ready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    // Byte collector and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
            rx_q.push_back(tx_if.tx_data);
            last_acc_cyc = cyc;
        end
        if (stalled_prev && reset === 1'b0) begin
            stall_seen++;
            if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== stall_data) stall_viol++;
        end
        stalled_prev = (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b0);
        stall_data   = tx_if.tx_data;
        if (wavenum !== wn_prev) wn_chg_cyc = cyc;
        wn_prev = wavenum;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [ADC_W-1:0] a, input logic [15:0] f);
        adc_data  = a;
        fir_data  = f;
        adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
        step();
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (tx_if.tx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_tx_valid: got %0b expected 0", tx_if.tx_valid);
        end
        checks++;
        if (tx_if.tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx_data: got %0h expected 00", tx_if.tx_data);
        end
        checks++;
        if (wavenum !== 16'h0000) begin
            errors++; $display("FAIL reset_wavenum: got %0h expected 0000", wavenum);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %0b expected 0", busy);
        end
        reset = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_wave();
        bit to;
        logic [7:0] got;
        rx_q.delete();
        acquireWave = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) strobe(12'(i), 16'h0);
        acquireWave = 1'b0;
        step();
        wait_idle(to);
        step();
        checks++;
        if (to) begin errors++; $display("FAIL wave_timeout: busy stuck, expected idle"); end
        checks++;
        if (rx_q.size() != 14) begin
            errors++; $display("FAIL wave_count: got %0d expected 14", rx_q.size());
        end
        for (int i = 0; i < 14; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_wave[i]) begin
                errors++; $display("FAIL wave_byte[%0d]: got %0h expected %0h", i, got, exp_wave[i]);
            end
        end
        checks++;
        if (wavenum !== 16'd1) begin
            errors++; $display("FAIL wave_wavenum: got %0h expected 1", wavenum);
        end
        checks++;
        if (wn_chg_cyc - last_acc_cyc != 2) begin
            errors++;
            $display("FAIL wave_done_latency: got %0d expected 2", wn_chg_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_fir();
        bit to;
        logic [7:0] got;
        rx_q.delete();
        acquireFIR = 1'b1;
        step();
        for (int i = 0; i < 3; i++) strobe(12'hABC, 16'h1234);
        acquireFIR = 1'b0;
        step();
        wait_idle(to);
        step();
        checks++;
        if (to) begin errors++; $display("FAIL fir_timeout: busy stuck, expected idle"); end
        checks++;
        if (rx_q.size() != 16) begin
            errors++; $display("FAIL fir_count: got %0d expected 16", rx_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_fir[i]) begin
                errors++; $display("FAIL fir_byte[%0d]: got %0h expected %0h", i, got, exp_fir[i]);
            end
        end
        checks++;
        if (wavenum !== 16'd2) begin
            errors++; $display("FAIL fir_wavenum: got %0h expected 2", wavenum);
        end
    endtask

    task automatic test_full();
        bit to;
        logic [7:0] got, want;
        int n_rx;
        rx_q.delete();
        acquireWave = 1'b1;
        step();
        for (int i = 1; i <= 40; i++) begin
            adc_data  = 12'(i);
            adc_valid = 1'b1;
            step();
        end
        adc_valid = 1'b0;
        // Toggle the switch while the frame is still being sent.
        acquireWave = 1'b0; step();
        acquireWave = 1'b1; step();
        acquireWave = 1'b0; step();
        acquireWave = 1'b1; step();
        acquireWave = 1'b0; step();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL full_busy_during_send: got %0b expected 1", busy);
        end
        wait_idle(to);
        step();
        checks++;
        if (to) begin errors++; $display("FAIL full_timeout: busy stuck, expected idle"); end
        checks++;
        if (rx_q.size() != 36) begin
            errors++; $display("FAIL full_count: got %0d expected 36", rx_q.size());
        end
        for (int i = 0; i < 36; i++) begin
            case (i)
                0: want = 8'hAA;
                1: want = 8'h77;
                2: want = 8'h00;
                3: want = 8'h10;
                default: want = (i % 2 == 0) ? 8'h00 : 8'((i - 4) / 2 + 1);
            endcase
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL full_byte[%0d]: got %0h expected %0h", i, got, want);
            end
        end
        n_rx = rx_q.size();
        repeat (20) step();
        checks++;
        if (busy !== 1'b0 || rx_q.size() != n_rx) begin
            errors++;
            $display("FAIL full_no_requeue: busy %0b bytes %0d, expected busy 0 bytes %0d",
                     busy, rx_q.size(), n_rx);
        end
        checks++;
        if (wavenum !== 16'd3) begin
            errors++; $display("FAIL full_wavenum: got %0h expected 3", wavenum);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [7:0] got;
        rx_q.delete();
        stall_viol = 0;
        stall_seen = 0;
        bp_en = 1'b1;
        acquireWave = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) strobe(12'(i), 16'h0);
        acquireWave = 1'b0;
        step();
        wait_idle(to);
        step();
        bp_en = 1'b0;
        step();
        checks++;
        if (to) begin errors++; $display("FAIL bp_timeout: busy stuck, expected idle"); end
        checks++;
        if (rx_q.size() != 14) begin
            errors++; $display("FAIL bp_count: got %0d expected 14", rx_q.size());
        end
        for (int i = 0; i < 14; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_wave[i]) begin
                errors++; $display("FAIL bp_byte[%0d]: got %0h expected %0h", i, got, exp_wave[i]);
            end
        end
        checks++;
        if (stall_viol != 0 || stall_seen == 0) begin
            errors++;
            $display("FAIL bp_stable: violations %0d stalls %0d, expected 0 violations, >0 stalls",
                     stall_viol, stall_seen);
        end
        checks++;
        if (wavenum !== 16'd4) begin
            errors++; $display("FAIL bp_wavenum: got %0h expected 4", wavenum);
        end
    endtask

    task automatic test_zero(input logic [15:0] want_wn, input bit use_fir_none);
        bit to;
        logic [7:0] got;
        rx_q.delete();
        acquireWave = 1'b1;
        step();
        acquireWave = 1'b0;
        step();
        wait_idle(to);
        step();
        checks++;
        if (to) begin errors++; $display("FAIL zero_timeout: busy stuck, expected idle"); end
        checks++;
        if (rx_q.size() != 4) begin
            errors++; $display("FAIL zero_count: got %0d expected 4", rx_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_zero[i]) begin
                errors++; $display("FAIL zero_byte[%0d]: got %0h expected %0h", i, got, exp_zero[i]);
            end
        end
        checks++;
        if (wavenum !== want_wn) begin
            errors++; $display("FAIL zero_wavenum: got %0h expected %0h", wavenum, want_wn);
        end
        if (use_fir_none) step();
    endtask

    task automatic test_both();
        bit to;
        logic [7:0] got;
        rx_q.delete();
        acquireWave = 1'b1;
        acquireFIR  = 1'b1;
        step();
        strobe(12'h00F, 16'h0042);
        acquireWave = 1'b0;
        acquireFIR  = 1'b0;
        step();
        wait_idle(to);
        step();
        checks++;
        if (to) begin errors++; $display("FAIL both_timeout: busy stuck, expected idle"); end
        checks++;
        if (rx_q.size() != 8) begin
            errors++; $display("FAIL both_count: got %0d expected 8", rx_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_both[i]) begin
                errors++; $display("FAIL both_byte[%0d]: got %0h expected %0h", i, got, exp_both[i]);
            end
        end
        checks++;
        if (wavenum !== 16'd6) begin
            errors++; $display("FAIL both_wavenum: got %0h expected 6", wavenum);
        end
    endtask

    task automatic test_wrap();
        force dut.wavenum_q = 16'hFFFF;
        step();
        release dut.wavenum_q;
        step();
        checks++;
        if (wavenum !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_preset: got %0h expected ffff", wavenum);
        end
        test_zero(16'h0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit to;
        bit reached;
        int n_rx;
        rx_q.delete();
        acquireWave = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) strobe(12'(i), 16'h0);
        acquireWave = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rx_q.size() >= 6) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!reached) begin
            errors++; $display("FAIL rmid_reach_send: got %0d bytes expected >=6", rx_q.size());
        end
        acquireWave = 1'b1;
        reset = 1'b1;
        step();
        checks++;
        if (tx_if.tx_valid !== 1'b0 || wavenum !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after_reset: valid %0b wavenum %0h busy %0b expected 0 0 0",
                     tx_if.tx_valid, wavenum, busy);
        end
        reset = 1'b0;
        n_rx = rx_q.size();
        repeat (10) step();
        checks++;
        if (busy !== 1'b0 || rx_q.size() != n_rx) begin
            errors++;
            $display("FAIL rmid_no_capture: busy %0b bytes %0d expected busy 0 bytes %0d",
                     busy, rx_q.size(), n_rx);
        end
        acquireWave = 1'b0;
        step();
        acquireWave = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rmid_fresh_edge: got busy %0b expected 1", busy);
        end
        acquireWave = 1'b0;
        step();
        wait_idle(to);
        step();
        checks++;
        if (to || wavenum !== 16'd1) begin
            errors++; $display("FAIL rmid_wavenum: got %0h expected 1", wavenum);
        end
    endtask

    initial begin
        test_reset();
        test_wave();
        test_fir();
        test_full();
        test_backpressure();
        test_zero(16'd5, 1'b1);
        test_both();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
